// File: rtl/matrix_fifo_pkg.sv
// Shared types and default sizes for the matrix-result readback path.
// Every rtl/ and tb/ file sets a timescale so the tools see one consistent time unit.
`timescale 1ns/1ps
package matrix_fifo_pkg;
  localparam int DATA_WIDTH_DEF  = 32;
  localparam int MEM_DEPTH_DEF   = 16;
  localparam int FIFO_DEPTH_DEF  = 16;
  localparam int DATA_AMOUNT_DEF = 16;

  typedef logic [DATA_WIDTH_DEF-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } rb_state_t;
endpackage

// File: rtl/fwft_fifo.sv
// First-word-fall-through FIFO; head is visible combinationally while not empty.
// Pointers carry an extra MSB so full and empty can be told apart.
`timescale 1ns/1ps
module fwft_fifo
  import matrix_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  localparam int PW = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  empty,
  output logic                  full,
  output logic [PW:0]           count
);
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW:0]           wr_ptr;
  logic [PW:0]           rd_ptr;

  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head  = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[PW-1:0]] <= push_data;
  end

  // The reader's credit rule must keep pushes away from a full buffer.
  always_ff @(posedge clk) begin
    if (reset) assert (!(push && full)) else $error("fwft_fifo: push while full");
  end
endmodule

// File: rtl/mem_readback_streamer.sv
// Reads DATA_AMOUNT words from the dual-port memory read port and streams them
// out through a local FWFT buffer with valid/ready handshake.
`timescale 1ns/1ps
module mem_readback_streamer
  import matrix_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int MEM_DEPTH   = MEM_DEPTH_DEF,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
  parameter int DATA_AMOUNT = DATA_AMOUNT_DEF,
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);
  localparam int CW = $clog2(DATA_AMOUNT + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] AMT        = CW'(DATA_AMOUNT);
  localparam logic [PW+1:0] CREDIT_MAX = (PW + 2)'(FIFO_DEPTH);

  rb_state_t             state_q, state_d;
  logic [CW-1:0]         issued_q, popped_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic                  pend_q;
  logic [DATA_WIDTH-1:0] last_q;
  logic                  rd_en, pop;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  fifo_empty, fifo_full;
  logic [PW:0]           fifo_count;
  logic [PW+1:0]         credit_used;

  // A read in flight has a reserved slot; a same-cycle pop earns no credit.
  assign credit_used = (PW + 2)'(fifo_count) + (PW + 2)'(pend_q);

  assign pop         = !fifo_empty && out_ready;
  assign out_valid   = !fifo_empty;
  assign out_data    = fifo_empty ? last_q : fifo_head;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign mem_rd_en   = rd_en;
  assign mem_rd_addr = base_q + ADDR_WIDTH'(issued_q);

  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = READ;
      READ: begin
        rd_en = (issued_q < AMT) && (credit_used < CREDIT_MAX) && !fifo_full;
        if (rd_en && (issued_q == AMT - 1'b1)) state_d = DRAIN;
      end
      DRAIN: if (pop && (popped_q == AMT - 1'b1)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      issued_q <= '0;
      popped_q <= '0;
      base_q   <= '0;
      pend_q   <= 1'b0;
      last_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= rd_en;
      if (state_q == IDLE && start) begin
        base_q   <= base_addr;
        issued_q <= '0;
        popped_q <= '0;
      end else begin
        if (rd_en) issued_q <= issued_q + 1'b1;
        if (pop)   popped_q <= popped_q + 1'b1;
      end
      // Holds the most recent accepted word so out_data is stable when empty.
      if (pop) last_q <= fifo_head;
    end
  end

  fwft_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (pend_q),
    .push_data (mem_rd_data),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );
endmodule
